// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between a set of requesters and rr_hold_arbiter.
// master = requester side, slave = arbiter side.
interface rr_hold_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [IDW-1:0]     grant_id;
   logic               hold_expired;
   logic               busy;

   modport master (
      output req,
      input  grant, grant_valid, grant_id, hold_expired, busy
   );

   modport slave (
      input  req,
      output grant, grant_valid, grant_id, hold_expired, busy
   );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with a per-win hold limit and a mandatory one-cycle gap
// between consecutive grants. All outputs come straight from flops.
module rr_hold_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               aclr_n,
   rr_hold_arbiter_if.slave   bus
);
   localparam int             HCW     = $clog2(MAX_HOLD + 1);
   localparam logic [IDW:0]   NREQ_W  = (IDW + 1)'(NUM_REQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
   localparam logic [HCW-1:0] HOLD_LIM = HCW'(MAX_HOLD);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               grant_valid_q, grant_valid_d;
   logic [IDW-1:0]     grant_id_q, grant_id_d;
   logic               hold_expired_q, hold_expired_d;
   logic               busy_q, busy_d;

   logic [IDW-1:0]     cand_idx [NUM_REQ];
   logic [IDW-1:0]     win_id;
   logic               any_req;
   logic [IDW-1:0]     ptr_after;

   // cand_idx[k] = (ptr + k) mod NUM_REQ, without a divider so any NUM_REQ works.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum          = {1'b0, ptr_q} + (IDW + 1)'(gi);
      assign cand_idx[gi] = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
   end

   // Scan from the farthest offset down so the nearest set request wins.
   always_comb begin
      win_id  = '0;
      any_req = |bus.req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req[cand_idx[k]]) begin
            win_id = cand_idx[k];
         end
      end
   end

   assign ptr_after = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      hold_cnt_d     = hold_cnt_q;
      grant_d        = grant_q;
      grant_valid_d  = grant_valid_q;
      grant_id_d     = grant_id_q;
      hold_expired_d = 1'b0;
      busy_d         = busy_q;

      case (state_q)
         S_IDLE, S_GAP: begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            hold_cnt_d    = '0;
            if (any_req) begin
               state_d          = S_GRANT;
               grant_d[win_id]  = 1'b1;
               grant_valid_d    = 1'b1;
               grant_id_d       = win_id;
               hold_cnt_d       = HCW'(1);
               busy_d           = 1'b1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_GRANT: begin
            if (!bus.req[grant_id_q] || hold_cnt_q == HOLD_LIM) begin
               // A dropped request takes precedence: no expiry pulse then.
               hold_expired_d = bus.req[grant_id_q];
               state_d        = S_GAP;
               grant_d        = '0;
               grant_valid_d  = 1'b0;
               grant_id_d     = '0;
               ptr_d          = ptr_after;
               hold_cnt_d     = '0;
               busy_d         = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end
         default: begin
            state_d       = S_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            hold_cnt_d    = '0;
            busy_d        = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q        <= S_IDLE;
         ptr_q          <= '0;
         hold_cnt_q     <= '0;
         grant_q        <= '0;
         grant_valid_q  <= 1'b0;
         grant_id_q     <= '0;
         hold_expired_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         hold_cnt_q     <= hold_cnt_d;
         grant_q        <= grant_d;
         grant_valid_q  <= grant_valid_d;
         grant_id_q     <= grant_id_d;
         hold_expired_q <= hold_expired_d;
         busy_q         <= busy_d;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.grant_valid  = grant_valid_q;
   assign bus.grant_id     = grant_id_q;
   assign bus.hold_expired = hold_expired_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: a 4-requester/MAX_HOLD=8 instance and a
// 3-requester/MAX_HOLD=1 instance, checked against a per-cycle owner model.
module tb_rr_hold_arbiter;
   logic clk;
   logic aclr_n;
   int   checks;
   int   errors;

   rr_hold_arbiter_if #(.NUM_REQ(4)) a_if ();
   rr_hold_arbiter_if #(.NUM_REQ(3)) b_if ();

   rr_hold_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut_a (
      .clk    (clk),
      .aclr_n (aclr_n),
      .bus    (a_if)
   );

   rr_hold_arbiter #(.NUM_REQ(3), .MAX_HOLD(1)) dut_b (
      .clk    (clk),
      .aclr_n (aclr_n),
      .bus    (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: who owns the resource, for how long, whether we sit in the gap.
   int         m_owner [2];
   int         m_cnt   [2];
   bit         m_gap   [2];
   int         m_ptr   [2];
   bit         m_he    [2];
   logic [8:0] exp_a;
   logic [8:0] exp_b;

   function automatic logic [8:0] obs_a();
      return {a_if.hold_expired, a_if.busy, a_if.grant_valid, a_if.grant_id, a_if.grant};
   endfunction

   function automatic logic [8:0] obs_b();
      return {1'b0, b_if.hold_expired, b_if.busy, b_if.grant_valid, b_if.grant_id, b_if.grant};
   endfunction

   function automatic logic [8:0] exp_bundle(input int inst);
      logic [3:0] g;
      logic [1:0] id;
      logic       v;
      logic       bz;
      logic [3:0] one;
      one = 4'b0001;
      v   = (m_owner[inst] >= 0);
      g   = v ? (one << m_owner[inst]) : 4'b0000;
      id  = v ? 2'(m_owner[inst]) : 2'b00;
      bz  = v || m_gap[inst];
      if (inst == 0) return {m_he[inst], bz, v, id, g};
      return {1'b0, m_he[inst], bz, v, id, g[2:0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = -1;
         m_cnt[i]   = 0;
         m_gap[i]   = 1'b0;
         m_ptr[i]   = 0;
         m_he[i]    = 1'b0;
      end
      exp_a = exp_bundle(0);
      exp_b = exp_bundle(1);
   endtask

   task automatic model_step(input int inst, input int rq);
      int n;
      int mh;
      bit still;
      n  = (inst != 0) ? 3 : 4;
      mh = (inst != 0) ? 1 : 8;
      m_he[inst] = 1'b0;
      if (m_owner[inst] >= 0) begin
         still = ((rq >> m_owner[inst]) & 1) == 1;
         if (!still || m_cnt[inst] == mh) begin
            m_he[inst]    = still;
            m_ptr[inst]   = (m_owner[inst] + 1) % n;
            m_owner[inst] = -1;
            m_cnt[inst]   = 0;
            m_gap[inst]   = 1'b1;
         end else begin
            m_cnt[inst]++;
         end
      end else begin
         m_gap[inst] = 1'b0;
         for (int k = 0; k < n; k++) begin
            int c;
            c = (m_ptr[inst] + k) % n;
            if (m_owner[inst] < 0 && ((rq >> c) & 1) == 1) begin
               m_owner[inst] = c;
               m_cnt[inst]   = 1;
            end
         end
      end
   endtask

   // One clock: drive requests, advance the model at the edge, settle 1ns.
   task automatic tick(input logic [3:0] ra, input logic [2:0] rb);
      a_if.req = ra;
      b_if.req = rb;
      @(posedge clk);
      model_step(0, int'(ra));
      model_step(1, int'(rb));
      exp_a = exp_bundle(0);
      exp_b = exp_bundle(1);
      #1;
   endtask

   task automatic do_reset();
      a_if.req = '0;
      b_if.req = '0;
      #2 aclr_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 aclr_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      a_if.req = '0;
      b_if.req = '0;
      aclr_n   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs_a() !== 9'd0 || obs_b() !== 9'd0) begin
         errors++;
         $display("FAIL reset_hold a=%b b=%b required 0", obs_a(), obs_b());
      end
      #3 aclr_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(4'b0000, 3'b000);
         checks++;
         if (obs_a() !== 9'd0 || obs_b() !== 9'd0) begin
            errors++;
            $display("FAIL idle cyc=%0d a=%b b=%b required 0", i, obs_a(), obs_b());
         end
      end
   endtask

   task automatic test_hold_limit();
      logic [3:0] eg;
      logic       ehe;
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         tick(4'b0100, 3'b000);
         eg  = (i % 9 != 0) ? 4'b0100 : 4'b0000;
         ehe = (i % 9 == 0);
         checks++;
         if (a_if.grant !== eg || a_if.hold_expired !== ehe) begin
            errors++;
            $display("FAIL hold_limit cyc=%0d grant=%b he=%b required grant=%b he=%b",
                     i, a_if.grant, a_if.hold_expired, eg, ehe);
         end
         checks++;
         if (obs_a() !== exp_a) begin
            errors++;
            $display("FAIL hold_limit_model cyc=%0d got=%b required=%b", i, obs_a(), exp_a);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] eg;
      logic [3:0] one;
      int         k;
      one = 4'b0001;
      do_reset();
      for (int i = 1; i <= 38; i++) begin
         tick(4'b1111, 3'b000);
         k  = (i - 1) % 9;
         eg = (k == 8) ? 4'b0000 : (one << (((i - 1) / 9) % 4));
         checks++;
         if (a_if.grant !== eg || obs_a() !== exp_a) begin
            errors++;
            $display("FAIL round_robin cyc=%0d grant=%b required=%b bundle=%b model=%b",
                     i, a_if.grant, eg, obs_a(), exp_a);
         end
      end
   endtask

   task automatic test_early_release();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         tick(4'b1010, 3'b000);
         checks++;
         if (a_if.grant !== 4'b0010 || a_if.grant_id !== 2'd1) begin
            errors++;
            $display("FAIL early_grant cyc=%0d grant=%b id=%0d required 0010 id 1",
                     i, a_if.grant, a_if.grant_id);
         end
      end
      tick(4'b1000, 3'b000);
      checks++;
      if (obs_a() !== 9'b0_1_0_00_0000) begin
         errors++;
         $display("FAIL early_gap got=%b required=010000000", obs_a());
      end
      tick(4'b1000, 3'b000);
      checks++;
      if (a_if.grant !== 4'b1000 || a_if.grant_id !== 2'd3 || obs_a() !== exp_a) begin
         errors++;
         $display("FAIL early_next grant=%b id=%0d required 1000 id 3", a_if.grant, a_if.grant_id);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) tick(4'b0100, 3'b000);
      checks++;
      if (a_if.grant !== 4'b0100) begin
         errors++;
         $display("FAIL async_pre grant=%b required 0100", a_if.grant);
      end
      #3 aclr_n = 1'b0;
      #1;
      checks++;
      if (obs_a() !== 9'd0) begin
         errors++;
         $display("FAIL async_immediate got=%b required 0", obs_a());
      end
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if (obs_a() !== 9'd0 || obs_b() !== 9'd0) begin
         errors++;
         $display("FAIL async_held a=%b b=%b required 0", obs_a(), obs_b());
      end
      #2 aclr_n = 1'b1;
      tick(4'b1111, 3'b000);
      checks++;
      if (a_if.grant !== 4'b0001 || obs_a() !== exp_a) begin
         errors++;
         $display("FAIL async_first grant=%b required 0001", a_if.grant);
      end
   endtask

   task automatic test_wrap_n3();
      logic [2:0] eg;
      logic [2:0] one;
      logic       ehe;
      one = 3'b001;
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         tick(4'b0000, 3'b111);
         eg  = (i % 2 == 1) ? (one << (((i - 1) / 2) % 3)) : 3'b000;
         ehe = (i % 2 == 0);
         checks++;
         if (b_if.grant !== eg || b_if.hold_expired !== ehe || obs_b() !== exp_b) begin
            errors++;
            $display("FAIL wrap cyc=%0d grant=%b he=%b required grant=%b he=%b",
                     i, b_if.grant, b_if.hold_expired, eg, ehe);
         end
      end
      tick(4'b0000, 3'b110);
      checks++;
      if (obs_b() !== 9'b0_0_1_0_00_000) begin
         errors++;
         $display("FAIL wrap_drop got=%b required=001000000", obs_b());
      end
      tick(4'b0000, 3'b110);
      checks++;
      if (b_if.grant !== 3'b010 || obs_b() !== exp_b) begin
         errors++;
         $display("FAIL wrap_after_drop grant=%b required 010", b_if.grant);
      end
   endtask

   task automatic test_random();
      logic [3:0] ra;
      logic [2:0] rb;
      ra = '0;
      rb = '0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) ra = 4'($urandom);
         if ($urandom_range(0, 2) == 0) rb = 3'($urandom);
         tick(ra, rb);
         checks++;
         if (obs_a() !== exp_a) begin
            errors++;
            $display("FAIL random_a cyc=%0d req=%b got=%b required=%b", i, ra, obs_a(), exp_a);
         end
         checks++;
         if (obs_b() !== exp_b) begin
            errors++;
            $display("FAIL random_b cyc=%0d req=%b got=%b required=%b", i, rb, obs_b(), exp_b);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_hold_limit();
      test_round_robin();
      test_early_release();
      test_async_reset();
      test_wrap_n3();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter sharing one resource (a counter or datapath slot) among NUM_REQ requesters.
- Grants one requester at a time and holds the grant while its request stays high, up to MAX_HOLD cycles.
- Inserts exactly one dead cycle between consecutive grants.
- The rotating priority pointer is a wrap-around modulo-NUM_REQ counter; the hold limit is a second up-counter.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- MAX_HOLD, 8, maximum consecutive grant cycles per win; legal range 1..255.
- IDW, $clog2(NUM_REQ), width of grant_id and of the priority pointer (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- aclr_n  input  1  reset, asynchronous, active-low; clock clk.
- req  input  NUM_REQ  per-requester request level; held high while the requester wants the resource.
- grant  output  NUM_REQ  one-hot registered grant; all zero when nobody is granted.
- grant_valid  output  1  high when grant is non-zero.
- grant_id  output  IDW  index of the granted requester; 0 when grant_valid=0.
- hold_expired  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit while req[grant_id] is still high.
- busy  output  1  high in GRANT or GAP state.

Behaviour:
- All outputs registered.
- Reset values:
  - Outputs: grant=0, grant_valid=0, grant_id=0, hold_expired=0, busy=0.
  - Internal: state=IDLE, ptr=0, hold_cnt=0.
- Reset asserted mid-grant clears everything immediately (asynchronously), with no completion of the grant. The first arbitration after reset starts from ptr=0.
- FSM states: IDLE, GRANT, GAP.
- IDLE: if req!=0 at a rising edge, the winner is the first set bit searching ptr, ptr+1, ... wrapping NUM_REQ-1 -> 0. Go to GRANT with grant=onehot(winner) and hold_cnt=1. Latency: req sampled at edge n -> grant visible after edge n.
- GRANT: grant stays constant. Each edge:
  - If req[grant_id]=0 -> release.
  - Else if hold_cnt==MAX_HOLD -> release with hold_expired=1 for the following cycle.
  - Else hold_cnt++.
- On release:
  - Next state is GAP; grant, grant_valid and grant_id go to 0.
  - ptr <= grant_id+1, wrapping to 0 after NUM_REQ-1. This must be correct for non-power-of-2 NUM_REQ.
  - hold_cnt <= 0.
- Simultaneous req drop and hold limit on the same edge: normal release, hold_expired stays 0.
- GAP: lasts exactly one cycle, grant=0, busy=1. Arbitration uses the same rule as IDLE on the GAP-cycle req. If any req is high, go directly to GRANT; else go to IDLE.
- Requests arriving or dropping during GRANT for non-granted requesters have no effect on the current grant.
- A requester asserting during GAP competes normally.
- The releasing requester has the lowest priority in the next arbitration, because ptr points past it.
- MAX_HOLD=1: every grant lasts exactly one cycle; hold_expired fires if req is still high.
- At most one grant bit is set in any cycle.
- Exactly one zero-grant cycle occurs between any two grants, including back-to-back grants to the same requester.
- hold_cnt width is $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD and never wraps.

Test Plan:
- Reset and idle: apply reset, then hold req=0 for 10 cycles -> all outputs stay 0, busy=0.
- Single requester, hold limit: req=4'b0100 held high, MAX_HOLD=8 -> grant=0100 and grant_id=2 for exactly 8 cycles, then hold_expired pulses once with 1 gap cycle, then grant=0100 again for 8 cycles.
- Round-robin fairness: req=4'b1111 held constant -> grant sequence 0001, gap, 0010, gap, 0100, gap, 1000, gap, 0001, each grant 8 cycles long.
- Early release: req[1] pulled low in the 3rd grant cycle with req[3]=1 pending -> grant[1] lasts 3 cycles, hold_expired=0, 1 gap cycle, then grant=1000.
- Asynchronous reset mid-grant: aclr_n low in the 5th grant cycle of requester 2, between clock edges -> grant=0 immediately. After release with req=1111, the first grant is 0001 (ptr back at 0).
- Wrap and simultaneous events with NUM_REQ=3, MAX_HOLD=1, req=3'b111 -> grant cycles 001, 010, 100, 001 with a gap between each and hold_expired after every grant. Dropping req[0] on its grant edge -> hold_expired stays 0 for that grant.
